// File: rtl/mem_responder.sv
// mem_responder: multi-cycle 16-bit data memory behind the memory stage.
// One request at a time; stall while in flight, one-cycle done pulse on completion.
module mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        enable,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);
    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [15:0]           addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [15:0]           rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  stall_q, stall_d;
    logic                  err_q, err_d;
    logic [15:0]           mem_q [WORDS];
    logic [15:0]           mem_d [WORDS];
    logic [DEPTH_LOG2-1:0] idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: if (enable) begin
                addr_d  = addr;
                wdata_d = data_in;
                wr_d    = wr;
                cnt_d   = 4'(LATENCY - 1);
                state_d = (LATENCY > 1) ? BUSY : DONE;
            end
            BUSY: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? DONE : BUSY;
            end
            default: state_d = IDLE;
        endcase
        // Upper address bits drop out here, so accesses alias modulo the depth.
        idx     = DEPTH_LOG2'(addr_d >> 1);
        done_d  = state_d == DONE;
        stall_d = state_d == BUSY;
        err_d   = done_d && addr_d[0];
        rdata_d = (done_d && !wr_d && !addr_d[0]) ? mem_q[idx] : '0;
        mem_d   = mem_q;
        if (done_d && wr_d && !addr_d[0])
            mem_d[idx] = wdata_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign data_out = rdata_q;
    assign done     = done_q;
    assign stall    = stall_q;
    assign err      = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (LATENCY=3 main instance,
// LATENCY=1 side instance), directed plan plus randomized read/write traffic.
module tb_mem_responder;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0, din = '0, dout;
    logic        en = 1'b0, wr = 1'b0, done, stall, err;
    logic [15:0] addr1 = '0, din1 = '0, dout1;
    logic        en1 = 1'b0, wr1 = 1'b0, done1, stall1, err1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_mem [256];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) u0 (
        .clk(clk), .rst(rst), .addr(addr), .data_in(din), .enable(en), .wr(wr),
        .data_out(dout), .done(done), .stall(stall), .err(err)
    );

    mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .addr(addr1), .data_in(din1), .enable(en1), .wr(wr1),
        .data_out(dout1), .done(done1), .stall(stall1), .err(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse; data_out/err must be 0 otherwise.
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rd_data", 32'(dout), 32'(e.data));
                    check("err_flag", 32'(err), 32'(e.err));
                end
            end else begin
                check("idle_data_out", 32'(dout), 32'd0);
                check("idle_err", 32'(err), 32'd0);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
    endtask

    task automatic req(input logic [15:0] a, input logic [15:0] d, input logic w);
        exp_t e;
        int   k, cycles, stalls, got;
        k = (int'(a) / 2) % 256;
        if (a % 2 == 1) e = '{data: 16'h0, err: 1'b1};
        else if (w) begin
            model_mem[k] = d;
            e = '{data: 16'h0, err: 1'b0};
        end else e = '{data: model_mem[k], err: 1'b0};
        @(negedge clk);
        addr = a; din = d; wr = w; en = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 en = 1'b0;
        cycles = 0; stalls = 0; got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            cycles++;
            if (done) got = 1;
            else if (stall) stalls++;
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(cycles), 32'(LAT));
        check("stall_cycles", 32'(stalls), 32'(LAT - 1));
    endtask

    initial begin
        int n;
        model_reset();
        // Reset held with enable high: everything quiet.
        #1 rst = 1'b0;
        en = 1'b1; addr = 16'h0010;
        repeat (2) begin
            @(negedge clk);
            check("rst_done", 32'(done), 32'd0);
            check("rst_stall", 32'(stall), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_dout", 32'(dout), 32'd0);
        end
        en = 1'b0;
        rst = 1'b1;
        req(16'h0010, 16'h0, 1'b0);
        // Write/read, misaligned write, aliasing.
        req(16'h0024, 16'hBEEF, 1'b1);
        req(16'h0024, 16'h0, 1'b0);
        req(16'h0025, 16'h1234, 1'b1);
        req(16'h0024, 16'h0, 1'b0);
        req(16'h0202, 16'h5A5A, 1'b1);
        req(16'h0002, 16'h0, 1'b0);
        // Reset during BUSY aborts the write and clears storage.
        @(negedge clk);
        addr = 16'h0030; din = 16'hFFFF; wr = 1'b1; en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(stall), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n++;
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done) n++;
        end
        check("midrst_no_done", 32'(n), 32'd0);
        model_reset();
        req(16'h0030, 16'h0, 1'b0);
        req(16'h0024, 16'h0, 1'b0);
        // Randomized traffic against the array model.
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
            req(a, 16'($urandom), 1'($urandom_range(0, 1)));
        end
        // LATENCY=1 instance: no stall, done one cycle after acceptance.
        @(negedge clk);
        addr1 = 16'h0010; wr1 = 1'b0; en1 = 1'b1;
        @(posedge clk);
        #1 en1 = 1'b0;
        @(negedge clk);
        check("l1_done", 32'(done1), 32'd1);
        check("l1_stall", 32'(stall1), 32'd0);
        check("l1_dout", 32'(dout1), 32'd0);
        @(negedge clk);
        en1 = 1'b1;
        n = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (done1) n++;
            check("l1_hold_stall", 32'(stall1), 32'd0);
        end
        en1 = 1'b0;
        check("l1_done_count", 32'(n), 32'd2);
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
